// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and writeback requester indices.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int AGE_W      = 4;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_age_counter.sv
// Per-requester wait counter; raises aged once the requester has lost AGE_LIMIT times in a row.
module wb_age_counter
  import mips_pkg::*;
#(
  parameter int AGE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic granted,
  output logic aged
);

  localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] age_r;
  logic [AGE_W-1:0] age_nxt_s;

  // Next age: clear when idle or served, otherwise count up and stick at the limit
  always_comb begin
    age_nxt_s = age_r;
    if (!valid || granted) begin
      age_nxt_s = {AGE_W{1'b0}};
    end else if (age_r != LIMIT_C) begin
      age_nxt_s = age_r + {{(AGE_W-1){1'b0}}, 1'b1};
    end else begin
      age_nxt_s = age_r;
    end
  end

  // Age state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_r <= {AGE_W{1'b0}};
    end else begin
      age_r <= age_nxt_s;
    end
  end

  assign aged = (age_r == LIMIT_C);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority with age override, registered write, $zero filter.
module wb_port_arbiter
  import mips_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int AGE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         RegWrite,
  output logic [REG_ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]            write_data,
  output logic [1:0]                   grant_id,
  output logic                         zero_drop
);

  logic [NUM_REQ-1:0]    aged_s;
  logic [NUM_REQ-1:0]    cand_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  xfer_s;
  logic [REG_ADDR_W-1:0] sel_reg_s;
  logic [DATA_W-1:0]     sel_data_s;
  logic [1:0]            sel_id_s;

  logic                  reg_write_r;
  logic [REG_ADDR_W-1:0] write_reg_r;
  logic [DATA_W-1:0]     write_data_r;
  logic [1:0]            grant_id_r;
  logic                  zero_drop_r;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
    wb_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (req_valid[g]),
      .granted (grant_s[g]),
      .aged    (aged_s[g])
    );
  end

  // Candidate set: aged requesters if any, else all valid ones; lowest index of the set wins
  always_comb begin
    cand_s = {NUM_REQ{1'b0}};
    if (hold) begin
      cand_s = {NUM_REQ{1'b0}};
    end else if (|(req_valid & aged_s)) begin
      cand_s = req_valid & aged_s;
    end else begin
      cand_s = req_valid;
    end
    grant_s = cand_s & (~cand_s + {{(NUM_REQ-1){1'b0}}, 1'b1});
  end

  assign req_ready = grant_s;
  assign xfer_s    = |(req_valid & grant_s);

  // One-hot grant lets the winner's fields be gathered with an AND-OR mux
  always_comb begin
    sel_reg_s  = REG_ZERO;
    sel_data_s = {DATA_W{1'b0}};
    sel_id_s   = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_reg_s  = sel_reg_s  | ({REG_ADDR_W{grant_s[i]}} & req_reg[i*REG_ADDR_W +: REG_ADDR_W]);
      sel_data_s = sel_data_s | ({DATA_W{grant_s[i]}} & req_data[i*DATA_W +: DATA_W]);
      sel_id_s   = sel_id_s   | (grant_s[i] ? 2'(i) : 2'd0);
    end
  end

  // Write-port output register; a $zero target is accepted but never raises RegWrite
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_r  <= 1'b0;
      write_reg_r  <= REG_ZERO;
      write_data_r <= {DATA_W{1'b0}};
      grant_id_r   <= 2'd0;
      zero_drop_r  <= 1'b0;
    end else if (xfer_s) begin
      reg_write_r  <= (sel_reg_s != REG_ZERO);
      zero_drop_r  <= (sel_reg_s == REG_ZERO);
      write_reg_r  <= sel_reg_s;
      write_data_r <= sel_data_s;
      grant_id_r   <= sel_id_s;
    end else begin
      reg_write_r  <= 1'b0;
      zero_drop_r  <= 1'b0;
    end
  end

  assign RegWrite   = reg_write_r;
  assign write_reg  = write_reg_r;
  assign write_data = write_data_r;
  assign grant_id   = grant_id_r;
  assign zero_drop  = zero_drop_r;

endmodule
